// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues one registered command at a time to a combinational ALU,
// waits a fixed settle time, then returns the sampled result over a valid/ready channel.
module alu_cmd_issuer #(
    parameter int DATA_W        = 32,
    parameter int OP_W          = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    localparam int SC_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t          state, state_nx;
    logic [SC_W-1:0] cnt;
    logic            issue, capture, done;

    always_comb begin
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        issue     = cmd_valid && cmd_ready;
        capture   = state == SETTLE && cnt == '0;
        done      = state == RESP && rsp_valid && rsp_ready;
        state_nx  = issue ? SETTLE : capture ? RESP : done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nx;
            if (issue) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_op  <= cmd_op;
                rsp_err <= cmd_op > OP_W'(1);
                cnt     <= SC_W'(SETTLE_CYCLES - 1);
            end
            if (state == SETTLE && cnt != '0)
                cnt <= cnt - SC_W'(1);
            if (capture) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_valid  <= 1'b1;
            end
            // counter saturates rather than wrapping
            if (done) begin
                rsp_valid <= 1'b0;
                if (~&op_count)
                    op_count <= op_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed checks of two issuers (settle 1 / settle 3 with a 2-bit counter),
// each driving its own reference add/sub ALU.
module tb_alu_cmd_issuer;
    logic        clk = 1'b0;
    logic        rstn [2];
    logic        cv [2], cr [2], az [2], rv [2], rr [2], rz [2], re [2], bs [2];
    logic [31:0] ca [2], cb [2], aa [2], ab [2], res [2], rres [2];
    logic [3:0]  cop [2], aop [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        return op == 4'd0 ? a + b : op == 4'd1 ? a - b : 32'd0;
    endfunction

    assign res[0] = alu_f(aa[0], ab[0], aop[0]);
    assign res[1] = alu_f(aa[1], ab[1], aop[1]);
    assign az[0]  = res[0] == 32'd0;
    assign az[1]  = res[1] == 32'd0;

    alu_cmd_issuer dut0 (
        .clk(clk), .rst_n(rstn[0]), .cmd_valid(cv[0]), .cmd_ready(cr[0]),
        .cmd_a(ca[0]), .cmd_b(cb[0]), .cmd_op(cop[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_op(aop[0]), .alu_result(res[0]), .alu_zero(az[0]),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_result(rres[0]), .rsp_zero(rz[0]),
        .rsp_err(re[0]), .busy(bs[0]), .op_count(cnt0)
    );

    alu_cmd_issuer #(.SETTLE_CYCLES(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rstn[1]), .cmd_valid(cv[1]), .cmd_ready(cr[1]),
        .cmd_a(ca[1]), .cmd_b(cb[1]), .cmd_op(cop[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_op(aop[1]), .alu_result(res[1]), .alu_zero(az[1]),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_result(rres[1]), .rsp_zero(rz[1]),
        .rsp_err(re[1]), .busy(bs[1]), .op_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
        int s;
        s = d == 0 ? 1 : 3;
        cv[d] = 1'b1; ca[d] = a; cb[d] = b; cop[d] = op;
        chk("cmd_ready_idle", 32'(cr[d]), 32'd1);
        step();
        cv[d] = 1'b0;
        chk("issued_alu_a", aa[d], a);
        chk("issued_alu_op", 32'(aop[d]), 32'(op));
        for (int i = 0; i < s; i++) begin
            chk("rsp_valid_early", 32'(rv[d]), 32'd0);
            step();
        end
        chk("rsp_valid", 32'(rv[d]), 32'd1);
        chk("rsp_result", rres[d], exp_res);
        chk("rsp_zero", 32'(rz[d]), 32'(exp_zero));
        chk("rsp_err", 32'(re[d]), 32'(exp_err));
        chk("busy_resp", 32'(bs[d]), 32'd1);
        rr[d] = 1'b1;
        step();
        rr[d] = 1'b0;
        chk("rsp_valid_drop", 32'(rv[d]), 32'd0);
        chk("cmd_ready_back", 32'(cr[d]), 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; cv[d] = 1'b0; rr[d] = 1'b0; ca[d] = '0; cb[d] = '0; cop[d] = '0;
        end
        #2;
        chk("rst_alu_a", aa[0], 32'd0);
        chk("rst_rsp_valid", 32'(rv[0]), 32'd0);
        chk("rst_op_count", 32'(cnt0), 32'd0);
        chk("rst_busy", 32'(bs[0]), 32'd0);
        #10;
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(cr[0]), 32'd1);

        run_op(0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b0);
        run_op(0, 32'd9, 32'd9, 4'd1, 32'd0, 1'b1, 1'b0);
        run_op(0, 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(0, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1, 1'b0);
        chk("op_count_4", 32'(cnt0), 32'd4);
        run_op(0, 32'd3, 32'd4, 4'h5, 32'd0, 1'b1, 1'b1);
        chk("op_count_unsup", 32'(cnt0), 32'd5);
        chk("alu_a_held_idle", aa[0], 32'd3);

        // backpressure with a second command waiting on cmd_valid
        cv[0] = 1'b1; ca[0] = 32'd100; cb[0] = 32'd23; cop[0] = 4'd0;
        step();
        ca[0] = 32'd1; cb[0] = 32'd2;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 32'(rv[0]), 32'd1);
            chk("bp_rsp_result", rres[0], 32'd123);
            chk("bp_cmd_ready", 32'(cr[0]), 32'd0);
            chk("bp_busy", 32'(bs[0]), 32'd1);
            chk("bp_alu_a", aa[0], 32'd100);
            step();
        end
        rr[0] = 1'b1;
        step();
        rr[0] = 1'b0;
        chk("bp_done_valid", 32'(rv[0]), 32'd0);
        chk("bp_result_held", rres[0], 32'd123);
        chk("bp_cmd_ready", 32'(cr[0]), 32'd1);
        chk("bp_op_count", 32'(cnt0), 32'd6);
        step();
        cv[0] = 1'b0;
        chk("next_alu_a", aa[0], 32'd1);
        step();
        chk("next_rsp_result", rres[0], 32'd3);
        rr[0] = 1'b1;
        step();
        rr[0] = 1'b0;
        chk("op_count_7", 32'(cnt0), 32'd7);

        // reset while in SETTLE abandons the op
        cv[1] = 1'b1; ca[1] = 32'd2; cb[1] = 32'd3; cop[1] = 4'd0;
        step();
        cv[1] = 1'b0;
        step();
        chk("s3_busy", 32'(bs[1]), 32'd1);
        rstn[1] = 1'b0;
        #1;
        chk("midrst_alu_a", aa[1], 32'd0);
        chk("midrst_busy", 32'(bs[1]), 32'd0);
        chk("midrst_rsp_valid", 32'(rv[1]), 32'd0);
        step();
        rstn[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_rsp", 32'(rv[1]), 32'd0);
            step();
        end

        run_op(1, 32'd2, 32'd3, 4'd0, 32'd5, 1'b0, 1'b0);
        run_op(1, 32'd8, 32'd3, 4'd1, 32'd5, 1'b0, 1'b0);
        run_op(1, 32'd7, 32'd7, 4'd1, 32'd0, 1'b1, 1'b0);
        chk("sat_count_3", 32'(cnt1), 32'd3);
        run_op(1, 32'd1, 32'd1, 4'd0, 32'd2, 1'b0, 1'b0);
        run_op(1, 32'd6, 32'd4, 4'hF, 32'd0, 1'b1, 1'b1);
        chk("sat_count_final", 32'(cnt1), 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
